booth_arbiter: RTL and testbench

//  Shares one 6-bit booth multiplier (clk/n_rst/start/Q/M -> product) between NREQ requesters.

---
 rtl/booth_arbiter.sv | 165 ++++++++++++++++
 tb/tb_booth_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_arbiter.sv
// booth_arbiter
// Shares a single booth multiplier between NREQ requesters. Requests are granted
// round-robin, one operation in flight at a time. The multiplier has no done flag,
// so completion is timed by a LATENCY down-counter. The result is returned on a
// tagged valid/ready port.
// Optional feature: define BOOTH_ARB_ZERO_BYPASS_EN to answer zero-operand
// requests directly with a product of 0, without starting the multiplier.
module booth_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 6,
    parameter int LATENCY = 7
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_q,
    input  logic [NREQ*WIDTH-1:0]     req_m,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]        rsp_product,
    output logic                      mul_start,
    output logic [WIDTH-1:0]          mul_q,
    output logic [WIDTH-1:0]          mul_m,
    input  logic [2*WIDTH-1:0]        mul_product
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(LATENCY + 1);

`ifdef BOOTH_ARB_ZERO_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 mul_start_q;
    logic [WIDTH-1:0]     mul_q_q;
    logic [WIDTH-1:0]     mul_m_q;
    logic                 rsp_valid_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic [2*WIDTH-1:0]   rsp_product_q;

    logic                 grant_found_s;
    logic [ID_W-1:0]      grant_idx_s;
    logic [WIDTH-1:0]     gnt_q_s;
    logic [WIDTH-1:0]     gnt_m_s;
    logic                 zero_s;

    // Round-robin search: first valid index at or after rr_ptr, wrapping.
    // Walking the offsets from highest to lowest lets the smallest offset win.
    always_comb begin
        logic [ID_W-1:0] idx_v;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        idx_v         = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_v         = ID_W'((int'(rr_ptr_q) + k) % NREQ);
            grant_idx_s   = req_valid[idx_v] ? idx_v : grant_idx_s;
            grant_found_s = grant_found_s | req_valid[idx_v];
        end
    end

    // Operand slice of the winner, zero detection and the next pointer value.
    always_comb begin
        gnt_q_s  = req_q[grant_idx_s*WIDTH +: WIDTH];
        gnt_m_s  = req_m[grant_idx_s*WIDTH +: WIDTH];
        zero_s   = BYPASS_EN && ((gnt_q_s == '0) || (gnt_m_s == '0));
        rr_ptr_d = (grant_idx_s == ID_W'(NREQ - 1)) ? '0 : grant_idx_s + 1'b1;
    end

    // One-hot accept, only while idle and out of reset, to the round-robin winner.
    always_comb begin
        req_ready = '0;
        if (n_rst && (state_q == S_IDLE) && grant_found_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Control FSM with registered multiplier and response outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            mul_start_q   <= 1'b0;
            mul_q_q       <= '0;
            mul_m_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found_s) begin
                        mul_q_q  <= gnt_q_s;
                        mul_m_q  <= gnt_m_s;
                        rsp_id_q <= grant_idx_s;
                        rr_ptr_q <= rr_ptr_d;
                        if (zero_s) begin
                            rsp_product_q <= '0;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= S_RESP;
                        end else begin
                            mul_start_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    mul_start_q <= 1'b0;
                    cnt_q       <= CNT_W'(LATENCY);
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_product_q <= mul_product;
                        rsp_valid_q   <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_RESP;
                    end
                end
                default: begin
                    mul_start_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_start   = mul_start_q;
    assign mul_q       = mul_q_q;
    assign mul_m       = mul_m_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Directed testbench for booth_arbiter with a behavioural booth multiplier model
// whose product is only valid LATENCY cycles after the start pulse.
module tb_booth_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 6;
    localparam int LATENCY = 7;

    logic                  clk = 1'b0;
    logic                  n_rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_q;
    logic [NREQ*WIDTH-1:0] req_m;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [11:0]           rsp_product;
    logic                  mul_start;
    logic [5:0]            mul_q;
    logic [5:0]            mul_m;
    logic [11:0]           mul_product = 12'hA5A;

    int total = 0;
    int fails = 0;
    int n_starts = 0;
    int mdl_cnt = 0;
    logic [5:0] mdl_a = 6'd0;
    logic [5:0] mdl_b = 6'd0;

    booth_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_q(req_q), .req_m(req_m),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product),
        .mul_start(mul_start), .mul_q(mul_q), .mul_m(mul_m),
        .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] sprod(input logic [5:0] a, input logic [5:0] b);
        logic signed [11:0] ea;
        logic signed [11:0] eb;
        ea = {{6{a[5]}}, a};
        eb = {{6{b[5]}}, b};
        return ea * eb;
    endfunction

    // Booth model: junk until LATENCY cycles after the start cycle.
    always @(posedge clk) begin
        if (mul_start) begin
            mdl_cnt     <= LATENCY - 1;
            mdl_a       <= mul_q;
            mdl_b       <= mul_m;
            mul_product <= 12'hA5A;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) mul_product <= sprod(mdl_a, mdl_b);
        end
    end

    always @(posedge clk) begin
        if (mul_start) n_starts <= n_starts + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] q, input logic [5:0] m);
        req_q[i*WIDTH +: WIDTH] = q;
        req_m[i*WIDTH +: WIDTH] = m;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_product"}, 32'(rsp_product), 32'd0);
        check({tag, "_mul_start"}, 32'(mul_start), 32'd0);
        check({tag, "_mul_q"}, 32'(mul_q), 32'd0);
        check({tag, "_mul_m"}, 32'(mul_m), 32'd0);
    endtask

    // Waits for an accept, checks it, then waits for the response and checks it.
    // Returns during the response cycle, before the consuming clock edge.
    task automatic do_op(input string tag, input logic [3:0] exp_ready, input logic [1:0] exp_id,
                         input logic [11:0] exp_prod, input int exp_lat, input int exp_starts);
        int waited;
        int lat;
        int s0;
        bit got;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 50) begin
            #1;
            if (req_ready != 4'b0000) got = 1'b1;
            else begin
                tick();
                waited++;
            end
        end
        check({tag, "_accept_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_req_ready"}, 32'(req_ready), 32'(exp_ready));
            s0 = n_starts;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 40) begin
                tick();
                lat++;
                if (rsp_valid) got = 1'b1;
            end
            check({tag, "_rsp_latency"}, 32'(lat), 32'(exp_lat));
            check({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
            check({tag, "_rsp_product"}, 32'(rsp_product), 32'(exp_prod));
            check({tag, "_mul_starts"}, 32'(n_starts - s0), 32'(exp_starts));
        end
    endtask

    initial begin
        n_rst     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        req_q     = '0;
        req_m     = '0;
        set_req(0, 6'b011110, 6'b110100);   // 30 * -12 = -360 = 12'hE98
        set_req(1, 6'b000010, 6'b111101);   //  2 *  -3 =   -6 = 12'hFFA
        set_req(2, 6'b111011, 6'b000111);   // -5 *   7 =  -35 = 12'hFDD
        set_req(3, 6'b011111, 6'b011111);   // 31 *  31 =  961 = 12'h3C1

        // Reset state, with all requesters already valid
        #2;
        check_all_zero("reset");
        tick();
        tick();
        n_rst = 1'b1;

        // Test 2: continuous valids from reset, grants 0,1,2,3,0
        do_op("rr0", 4'b0001, 2'd0, 12'hE98, 9, 1);
        do_op("rr1", 4'b0010, 2'd1, 12'hFFA, 9, 1);
        do_op("rr2", 4'b0100, 2'd2, 12'hFDD, 9, 1);
        do_op("rr3", 4'b1000, 2'd3, 12'h3C1, 9, 1);
        do_op("rr4", 4'b0001, 2'd0, 12'hE98, 9, 1);

        // Test 3: pointer now 1; grant 3, then with only 1 and 3 valid: 1 then 3
        req_valid = 4'b1000;
        do_op("wrap3", 4'b1000, 2'd3, 12'h3C1, 9, 1);
        req_valid = 4'b1010;
        do_op("wrap1", 4'b0010, 2'd1, 12'hFFA, 9, 1);
        do_op("wrap3b", 4'b1000, 2'd3, 12'h3C1, 9, 1);
        req_valid = 4'b0000;
        tick();

        // Test 1: single op, also checking the multiplier interface
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        check("single_start", 32'(mul_start), 32'd1);
        check("single_mul_q", 32'(mul_q), 32'h1E);
        check("single_mul_m", 32'(mul_m), 32'h34);
        check("single_ready_busy", 32'(req_ready), 32'd0);
        tick();
        check("single_start_off", 32'(mul_start), 32'd0);
        for (int c = 3; c <= 8; c++) begin
            tick();
            check("single_no_early_valid", 32'(rsp_valid), 32'd0);
        end
        tick();
        check("single_valid_c9", 32'(rsp_valid), 32'd1);
        check("single_id", 32'(rsp_id), 32'd0);
        check("single_product", 32'(rsp_product), 32'hE98);
        tick();
        check("single_valid_drop", 32'(rsp_valid), 32'd0);

        // Test 4: back-pressure for 20 cycles, other requesters waiting
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        do_op("bp", 4'b0001, 2'd0, 12'hE98, 9, 1);
        req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_id", 32'(rsp_id), 32'd0);
            check("bp_product", 32'(rsp_product), 32'hE98);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd0);

        // Test 5: reset during WAIT
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        check_all_zero("rst_wait");
        tick();
        n_rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("rst_no_stale_valid", 32'(rsp_valid), 32'd0);
            check("rst_no_start", 32'(mul_start), 32'd0);
        end
        req_valid = 4'b0010;
        do_op("rst_newop", 4'b0010, 2'd1, 12'hFFA, 9, 1);
        req_valid = 4'b0000;
        tick();

        // Reset during ISSUE drops mul_start at once
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        check("issue_start", 32'(mul_start), 32'd1);
        n_rst = 1'b0;
        #1;
        check("issue_rst_start", 32'(mul_start), 32'd0);
        tick();
        n_rst = 1'b1;

        // Test 6: zero operand on requester 2
        set_req(2, 6'b000000, 6'b100000);
        req_valid = 4'b0100;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
        do_op("zero", 4'b0100, 2'd2, 12'h000, 1, 0);
`else
        do_op("zero", 4'b0100, 2'd2, 12'h000, 9, 1);
`endif
        req_valid = 4'b0000;
        tick();
        check("zero_done", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
